// File: rtl/axi_nmst_arb.sv
// axi_nmst_arb: N-master to 1-slave arbiter/mux for the simplified AXI bus.
// Shared address channel with round-robin grant into one output register,
// write data steered in address order via a master-index queue, and read
// beats routed back by the master index carried in the top bits of the ID.
module axi_nmst_arb #(
    parameter int NUM_MST  = 3,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int LEN_W    = 4,
    parameter int WQ_DEPTH = 4,
    localparam int MIDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
    localparam int TID_W   = MIDX_W + ID_W,
    localparam int STRB_W  = DATA_W / 8,
    localparam int LVL_W   = $clog2(WQ_DEPTH) + 1
) (
    input  logic                        gclk,
    input  logic                        gresetn,
    input  logic [NUM_MST*ID_W-1:0]     s_aid,
    input  logic [NUM_MST*ADDR_W-1:0]   s_aaddr,
    input  logic [NUM_MST-1:0]          s_avalid,
    input  logic [NUM_MST-1:0]          s_awrite,
    input  logic [NUM_MST*LEN_W-1:0]    s_alen,
    input  logic [NUM_MST*3-1:0]        s_asize,
    input  logic [NUM_MST*2-1:0]        s_aburst,
    output logic [NUM_MST-1:0]          s_aready,
    input  logic [NUM_MST*DATA_W-1:0]   s_wdata,
    input  logic [NUM_MST*STRB_W-1:0]   s_wstrb,
    input  logic [NUM_MST-1:0]          s_wlast,
    input  logic [NUM_MST-1:0]          s_wvalid,
    output logic [NUM_MST-1:0]          s_wready,
    output logic [NUM_MST*ID_W-1:0]     s_rid,
    output logic [NUM_MST*DATA_W-1:0]   s_rdata,
    output logic [NUM_MST-1:0]          s_rlast,
    output logic [NUM_MST-1:0]          s_rvalid,
    input  logic [NUM_MST-1:0]          s_rready,
    output logic [TID_W-1:0]            m_aid,
    output logic [ADDR_W-1:0]           m_aaddr,
    output logic                        m_awrite,
    output logic [LEN_W-1:0]            m_alen,
    output logic [2:0]                  m_asize,
    output logic [1:0]                  m_aburst,
    output logic                        m_avalid,
    input  logic                        m_aready,
    output logic [TID_W-1:0]            m_wid,
    output logic [DATA_W-1:0]           m_wdata,
    output logic [STRB_W-1:0]           m_wstrb,
    output logic                        m_wlast,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    input  logic [TID_W-1:0]            m_rid,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic                        m_rlast,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    output logic [LVL_W-1:0]            wq_level,
    output logic                        rid_err
);

    localparam int WQ_AW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

    logic [MIDX_W-1:0] rr_ptr;
    logic [NUM_MST-1:0] elig;
    logic [MIDX_W-1:0] win;
    logic              found;
    logic              capture;
    logic              grant;
    logic              push;
    logic              pop;
    logic              wq_full;
    logic              wq_nempty;
    logic [ID_W-1:0]   sel_aid;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [2:0]        sel_size;
    logic [1:0]        sel_burst;
    logic              sel_write;

    logic [MIDX_W-1:0] wq_mst [WQ_DEPTH];
    logic [ID_W-1:0]   wq_id  [WQ_DEPTH];
    logic [WQ_AW-1:0]  wr_ptr;
    logic [WQ_AW-1:0]  rd_ptr;
    logic [MIDX_W-1:0] head;
    logic [ID_W-1:0]   head_id;

    logic [MIDX_W-1:0] ridx;
    logic              rid_hit;
    logic              rid_bad;

    // Round-robin pick among masters; writes are held off while the queue is full.
    always_comb begin
        int idx;
        wq_full = (wq_level == LVL_W'(WQ_DEPTH));
        elig    = s_avalid & ~(s_awrite & {NUM_MST{wq_full}});
        win     = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_MST) idx = idx - NUM_MST;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = MIDX_W'(idx);
            end
        end
        capture = !m_avalid || m_aready;
        // No grants while reset is held, so s_aready reads 0 throughout reset.
        grant   = capture && found && gresetn;
    end

    // Mux the winner's address fields and drive its one-cycle s_aready pulse.
    always_comb begin
        s_aready  = '0;
        sel_aid   = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        sel_write = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (win == MIDX_W'(k)) begin
                s_aready[k] = grant;
                sel_aid     = s_aid[k*ID_W +: ID_W];
                sel_addr    = s_aaddr[k*ADDR_W +: ADDR_W];
                sel_len     = s_alen[k*LEN_W +: LEN_W];
                sel_size    = s_asize[k*3 +: 3];
                sel_burst   = s_aburst[k*2 +: 2];
                sel_write   = s_awrite[k];
            end
        end
        push = grant && sel_write;
    end

    // Address output register and round-robin pointer.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) begin
            m_aid    <= '0;
            m_aaddr  <= '0;
            m_awrite <= 1'b0;
            m_alen   <= '0;
            m_asize  <= '0;
            m_aburst <= '0;
            m_avalid <= 1'b0;
            rr_ptr   <= '0;
        end else if (capture) begin
            m_avalid <= found;
            if (found) begin
                m_aid    <= {win, sel_aid};
                m_aaddr  <= sel_addr;
                m_awrite <= sel_write;
                m_alen   <= sel_len;
                m_asize  <= sel_size;
                m_aburst <= sel_burst;
                rr_ptr   <= (win == MIDX_W'(NUM_MST - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    assign wq_nempty = (wq_level != '0);
    assign head      = wq_mst[rd_ptr];
    assign head_id   = wq_id[rd_ptr];
    assign m_wid     = {head, head_id};

    // Steer W from the master at the queue head; nothing passes while empty.
    always_comb begin
        s_wready = '0;
        m_wvalid = 1'b0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (wq_nempty && head == MIDX_W'(k)) begin
                m_wvalid    = s_wvalid[k];
                m_wdata     = s_wdata[k*DATA_W +: DATA_W];
                m_wstrb     = s_wstrb[k*STRB_W +: STRB_W];
                m_wlast     = s_wlast[k];
                s_wready[k] = m_wready;
            end
        end
        pop = m_wvalid && m_wready && m_wlast;
    end

    // Write-order queue: push at address capture, pop on the last W beat.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wq_level <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                wq_mst[i] <= '0;
                wq_id[i]  <= '0;
            end
        end else begin
            if (push) begin
                wq_mst[wr_ptr] <= win;
                wq_id[wr_ptr]  <= sel_aid;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      wq_level <= wq_level + 1'b1;
            else if (pop && !push) wq_level <= wq_level - 1'b1;
        end
    end

    assign ridx    = m_rid[TID_W-1 -: MIDX_W];
    assign s_rid   = {NUM_MST{m_rid[ID_W-1:0]}};
    assign s_rdata = {NUM_MST{m_rdata}};
    assign s_rlast = {NUM_MST{m_rlast}};

    // Route R beats by master index; unknown indices are swallowed.
    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b1;
        rid_hit  = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (ridx == MIDX_W'(k)) begin
                s_rvalid[k] = m_rvalid;
                m_rready    = s_rready[k];
                rid_hit     = 1'b1;
            end
        end
        rid_bad = m_rvalid && !rid_hit;
    end

    // Sticky flag for returns addressed to a master that does not exist.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) rid_err <= 1'b0;
        else if (rid_bad) rid_err <= 1'b1;
    end

endmodule

// File: tb/tb_axi_nmst_arb.sv
// Directed bench for axi_nmst_arb with 3 masters and default widths.
module tb_axi_nmst_arb;

    localparam int N  = 3;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 4;
    localparam int SW = DW / 8;
    localparam int TW = 6;

    logic            gclk;
    logic            gresetn;
    logic [N*IW-1:0] s_aid;
    logic [N*AW-1:0] s_aaddr;
    logic [N-1:0]    s_avalid;
    logic [N-1:0]    s_awrite;
    logic [N*LW-1:0] s_alen;
    logic [N*3-1:0]  s_asize;
    logic [N*2-1:0]  s_aburst;
    logic [N-1:0]    s_aready;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N-1:0]    s_wlast;
    logic [N-1:0]    s_wvalid;
    logic [N-1:0]    s_wready;
    logic [N*IW-1:0] s_rid;
    logic [N*DW-1:0] s_rdata;
    logic [N-1:0]    s_rlast;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [TW-1:0]   m_aid;
    logic [AW-1:0]   m_aaddr;
    logic            m_awrite;
    logic [LW-1:0]   m_alen;
    logic [2:0]      m_asize;
    logic [1:0]      m_aburst;
    logic            m_avalid;
    logic            m_aready;
    logic [TW-1:0]   m_wid;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_wlast;
    logic            m_wvalid;
    logic            m_wready;
    logic [TW-1:0]   m_rid;
    logic [DW-1:0]   m_rdata;
    logic            m_rlast;
    logic            m_rvalid;
    logic            m_rready;
    logic [2:0]      wq_level;
    logic            rid_err;

    int n_chk = 0;
    int n_err = 0;

    axi_nmst_arb #(.NUM_MST(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW),
                   .LEN_W(LW), .WQ_DEPTH(4)) dut (
        .gclk(gclk), .gresetn(gresetn),
        .s_aid(s_aid), .s_aaddr(s_aaddr), .s_avalid(s_avalid), .s_awrite(s_awrite),
        .s_alen(s_alen), .s_asize(s_asize), .s_aburst(s_aburst), .s_aready(s_aready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_aid(m_aid), .m_aaddr(m_aaddr), .m_awrite(m_awrite), .m_alen(m_alen),
        .m_asize(m_asize), .m_aburst(m_aburst), .m_avalid(m_avalid), .m_aready(m_aready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .wq_level(wq_level), .rid_err(rid_err)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    initial begin
        gresetn  = 1'b0;
        s_aid    = '0; s_aaddr = '0; s_avalid = '0; s_awrite = '0;
        s_alen   = '0; s_asize = '0; s_aburst = '0;
        s_wdata  = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0;
        s_rready = '0;
        m_aready = 1'b0; m_wready = 1'b0;
        m_rid    = '0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        #12;
        chk("rst_avalid", m_avalid, 0);
        chk("rst_aready", s_aready, 0);
        chk("rst_riderr", rid_err, 0);
        chk("rst_level",  wq_level, 0);
        chk("rst_aid",    m_aid, 0);
        gresetn = 1'b1;
        tick();

        // Round-robin reads from all three masters
        s_aid    = {4'd3, 4'd2, 4'd1};
        s_aaddr  = {32'h300, 32'h200, 32'h100};
        s_avalid = 3'b111;
        s_awrite = 3'b000;
        m_aready = 1'b1;
        #1;
        chk("rr_g0", s_aready, 3'b001);
        tick();
        chk("rr_aid0", m_aid, 6'h01);
        chk("rr_addr0", m_aaddr, 32'h100);
        chk("rr_g1", s_aready, 3'b010);
        tick();
        chk("rr_aid1", m_aid, 6'h12);
        chk("rr_g2", s_aready, 3'b100);
        tick();
        chk("rr_aid2", m_aid, 6'h23);
        chk("rr_g0b", s_aready, 3'b001);

        // Backpressure on the address output
        m_aready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_aid", m_aid, 6'h23);
            chk("bp_avalid", m_avalid, 1);
            chk("bp_noready", s_aready, 0);
        end
        m_aready = 1'b1;
        #1;
        chk("bp_release", s_aready, 3'b001);
        tick();
        chk("bp_aid_next", m_aid, 6'h01);
        s_avalid = 3'b000;
        #1;
        chk("idle_noready", s_aready, 0);
        tick();
        chk("idle_avalid", m_avalid, 0);

        // Master 2 fills the write queue with m_wready low
        s_aid[8 +: 4] = 4'd9;
        s_avalid = 3'b100;
        s_awrite = 3'b100;
        #1;
        chk("wq_g0", s_aready, 3'b100);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wq_lvl", wq_level, 3'(i));
            chk("wq_g", s_aready, 3'b100);
        end
        tick();
        chk("wq_full_lvl", wq_level, 4);
        chk("wq_full_stall", s_aready, 0);
        tick();
        chk("wq_full_lvl2", wq_level, 4);
        chk("wq_full_stall2", s_aready, 0);
        s_wdata[128 +: 64] = 64'hAAAA_5555_0000_1111;
        s_wstrb[16 +: 8]   = 8'hFF;
        s_wlast  = 3'b100;
        s_wvalid = 3'b100;
        m_wready = 1'b1;
        #1;
        chk("wq_wvalid", m_wvalid, 1);
        chk("wq_wid", m_wid, 6'h29);
        chk("wq_wdata", m_wdata, 64'hAAAA_5555_0000_1111);
        chk("wq_wready", s_wready, 3'b100);
        chk("wq_popcyc_stall", s_aready, 0);
        tick();
        m_wready = 1'b0;
        s_wvalid = 3'b000;
        #1;
        chk("wq_after_pop_lvl", wq_level, 3);
        chk("wq_5th_grant", s_aready, 3'b100);
        tick();
        s_avalid = 3'b000;
        chk("wq_5th_lvl", wq_level, 4);
        m_wready = 1'b1;
        s_wvalid = 3'b100;
        for (int i = 0; i < 4; i++) tick();
        chk("wq_drain_lvl", wq_level, 0);
        chk("wq_empty_wvalid", m_wvalid, 0);
        chk("wq_empty_wready", s_wready, 0);
        s_wvalid = 3'b000;
        s_wlast  = 3'b000;
        m_wready = 1'b0;

        // Master 1 burst of 4 then master 0 single beat, W presented early
        s_aid[4 +: 4]  = 4'd4;
        s_alen[4 +: 4] = 4'd3;
        s_aid[0 +: 4]  = 4'd6;
        s_alen[0 +: 4] = 4'd0;
        s_wdata[0 +: 64] = 64'hD0;
        s_wlast  = 3'b001;
        s_wvalid = 3'b011;
        s_avalid = 3'b010;
        s_awrite = 3'b010;
        #1;
        chk("ord_empty_wvalid", m_wvalid, 0);
        chk("ord_g1", s_aready, 3'b010);
        tick();
        s_avalid = 3'b001;
        s_awrite = 3'b001;
        #1;
        chk("ord_g0", s_aready, 3'b001);
        chk("ord_head_wvalid", m_wvalid, 1);
        chk("ord_wready_lo", s_wready, 0);
        tick();
        s_avalid = 3'b000;
        m_wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_wdata[64 +: 64] = 64'h100 + 64'(b);
            s_wlast[1] = (b == 3);
            #1;
            chk("ord_m1_data", m_wdata, 64'h100 + 64'(b));
            chk("ord_m1_last", m_wlast, (b == 3));
            chk("ord_m1_wready", s_wready, 3'b010);
            chk("ord_m1_wid", m_wid, 6'h14);
            tick();
        end
        chk("ord_m0_data", m_wdata, 64'hD0);
        chk("ord_m0_last", m_wlast, 1);
        chk("ord_m0_wready", s_wready, 3'b001);
        chk("ord_m0_wid", m_wid, 6'h06);
        tick();
        chk("ord_lvl", wq_level, 0);
        s_wvalid = 3'b000;
        s_wlast  = 3'b000;

        // Read return routing
        s_rready = 3'b011;
        m_rvalid = 1'b1;
        m_rid    = 6'h15;
        m_rdata  = 64'h55;
        m_rlast  = 1'b1;
        #1;
        chk("rd1_rvalid", s_rvalid, 3'b010);
        chk("rd1_rid", s_rid[4 +: 4], 5);
        chk("rd1_rdata", s_rdata[64 +: 64], 64'h55);
        chk("rd1_rready", m_rready, 1);
        m_rid = 6'h27;
        #1;
        chk("rd2_rvalid", s_rvalid, 3'b100);
        chk("rd2_rready", m_rready, 0);
        m_rid = 6'h3F;
        #1;
        chk("rdbad_rready", m_rready, 1);
        chk("rdbad_rvalid", s_rvalid, 0);
        chk("rdbad_pre", rid_err, 0);
        tick();
        m_rvalid = 1'b0;
        chk("rdbad_err", rid_err, 1);
        tick();
        chk("rdbad_sticky", rid_err, 1);

        // Reset in the middle of a write
        s_avalid = 3'b001;
        s_awrite = 3'b001;
        s_wvalid = 3'b001;
        s_wlast  = 3'b001;
        m_wready = 1'b0;
        tick();
        chk("mid_lvl", wq_level, 1);
        chk("mid_wvalid", m_wvalid, 1);
        gresetn = 1'b0;
        #1;
        chk("mid_rst_err", rid_err, 0);
        chk("mid_rst_lvl", wq_level, 0);
        chk("mid_rst_avalid", m_avalid, 0);
        chk("mid_rst_wvalid", m_wvalid, 0);
        chk("mid_rst_aready", s_aready, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_nmst_arb.md
Name: axi_nmst_arb

Overview:
- Parametrised N-master to 1-slave arbiter/mux for the team's simplified AXI bus: shared address channel (awrite selects direction), W channel, R channel, no B channel.
- Successor to the fixed three-master bus wrapper. Master count and widths are parameters.
- Adds round-robin arbitration, a registered address stage, in-order write-data steering via a master-index queue, and ID-tagged read-return routing.
- Sits between client DMAs (audio, demux, gdma, ...) and the DDR AXI port.

Parameters:
- NUM_MST, 3, number of upstream masters (2..8); MIDX_W = max(1, clog2(NUM_MST)) derived locally.
- ID_W, 4, upstream ID width.
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width = DATA_W/8.
- LEN_W, 4, burst length field width.
- WQ_DEPTH, 4, max accepted write addresses whose data is not yet complete (power of 2).

Ports:
- gclk  in  1  clock.
- gresetn  in  1  async active-low reset.
- s_aid  in  NUM_MST*ID_W  per-master address ID, master k at slice k.
- s_aaddr  in  NUM_MST*ADDR_W  address.
- s_avalid  in  NUM_MST  address valid.
- s_awrite  in  NUM_MST  1 = write.
- s_alen  in  NUM_MST*LEN_W  burst length.
- s_asize  in  NUM_MST*3  burst size.
- s_aburst  in  NUM_MST*2  burst type.
- s_aready  out  NUM_MST  address accepted.
- s_wdata  in  NUM_MST*DATA_W  write data.
- s_wstrb  in  NUM_MST*DATA_W/8  write strobes.
- s_wlast  in  NUM_MST  last beat.
- s_wvalid  in  NUM_MST  write valid.
- s_wready  out  NUM_MST  write ready.
- s_rid  out  NUM_MST*ID_W  read ID (low ID_W bits of m_rid).
- s_rdata  out  NUM_MST*DATA_W  read data.
- s_rlast  out  NUM_MST  last read beat.
- s_rvalid  out  NUM_MST  read valid.
- s_rready  in  NUM_MST  read ready.
- m_aid  out  MIDX_W+ID_W  {master index, aid}.
- m_aaddr  out  ADDR_W  address.
- m_awrite  out  1  1 = write.
- m_alen  out  LEN_W  burst length.
- m_asize  out  3  burst size.
- m_aburst  out  2  burst type.
- m_avalid  out  1  address valid.
- m_aready  in  1  address ready.
- m_wid  out  MIDX_W+ID_W  write ID.
- m_wdata  out  DATA_W  write data.
- m_wstrb  out  DATA_W/8  write strobes.
- m_wlast  out  1  last beat.
- m_wvalid  out  1  write valid.
- m_wready  in  1  write ready.
- m_rid  in  MIDX_W+ID_W  read ID.
- m_rdata  in  DATA_W  read data.
- m_rlast  in  1  last read beat.
- m_rvalid  in  1  read valid.
- m_rready  out  1  read ready.
- wq_level  out  clog2(WQ_DEPTH)+1  write-queue occupancy.
- rid_err  out  1  sticky bad-return flag.

Behaviour:
Reset:
- All m_a* registers, m_avalid, s_aready, rid_err = 0.
- Write queue empty; wq_level = 0.
- Round-robin pointer = 0, so master 0 has top priority.

Address stage (one output register):
- Capture is allowed when m_avalid=0 or (m_avalid & m_aready). This gives full throughput, one address per cycle.
- Eligible master = s_avalid[k] & (!s_awrite[k] | queue not full). Fullness is evaluated before a same-cycle pop.
- Winner = first eligible at or after the RR pointer, mod NUM_MST.
- On capture: s_aready[winner]=1, combinational, that cycle only. Register is loaded with m_aid = {winner, s_aid[winner]}. m_avalid=1 from the next cycle, giving 1-cycle latency.
- After capture, the RR pointer becomes winner+1 mod NUM_MST.
- m_a* stay stable while m_avalid & !m_aready.
- No eligible master: m_avalid deasserts after its handshake.

Write queue:
- Push the winner index when a write is captured into the address register, not at m_aready.
- Head master h, queue non-empty:
  - m_wvalid = s_wvalid[h]; m_wdata, m_wstrb and m_wlast come from h.
  - m_wid = {h, id}, where id is the aid stored with the queue entry.
  - s_wready[h] = m_wready. All other s_wready = 0.
- Pop on m_wvalid & m_wready & m_wlast. The next burst may start the following cycle.
- Queue empty: m_wvalid=0 and every s_wready=0, so data never precedes its address.
- Simultaneous push and pop: level unchanged.

Read return (combinational, 0 latency):
- idx = m_rid[top MIDX_W bits].
- s_rvalid[idx] = m_rvalid and all others are 0. m_rready = s_rready[idx].
- s_rid, s_rdata, s_rlast are broadcast to all masters.
- idx >= NUM_MST: m_rready=1, the beat is dropped, and rid_err is set. rid_err is cleared only by reset.

Reset mid-operation: all in-flight bursts are abandoned, the queue is cleared, and outputs return to reset values immediately, because reset is asynchronous.

Test Plan:
- All 3 masters hold reads (aid 1,2,3) with m_aready=1 → grants 0,1,2,0 on consecutive cycles. m_aid = {0,1},{1,2},{2,3}.
- m_aready held 0 for 5 cycles with m_avalid high → m_a* stable, no s_aready pulses. Release → next grant on the same cycle as the handshake.
- Master 2 issues 5 single-beat writes with m_wready=0 → 4 accepted, wq_level=4, 5th stalled. One wlast handshake → 5th accepted next cycle, level stays 4.
- Master 1 write (alen=3) then master 0 write (alen=0), both W valid early → 4 beats of master 1 with m_wlast on beat 4, then master 0's beat. s_wready[0]=0 during master 1's beats.
- R beats with m_rid = {1,5}, {2,7}, s_rready[2]=0 → s_rvalid[1] with s_rid=5 passes. {2,7} stalls with m_rready=0.
- NUM_MST=3, m_rid idx=3 → beat consumed, rid_err=1 and stays 1. gresetn low → rid_err=0, queue empty.
